// File: rtl/gpt_ic_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : gpt_ic_conditioner
// Purpose  : Input conditioning for one timer capture channel. Synchronises
//            the raw pin, applies a strobed digital noise filter, qualifies
//            edges of the selected polarity, prescales them into a one-cycle
//            capture event, and keeps sticky capture/overcapture flags.
// Revision : 1.0 - initial release
// ============================================================================
module gpt_ic_conditioner #(
  parameter int FILT_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              aclk_i,
  input  logic              areset_i,
  input  logic              en_i,
  input  logic              ch_i,
  input  logic [FILT_W-1:0] filt_n_i,
  input  logic [1:0]        fdiv_i,
  input  logic [1:0]        pol_i,
  input  logic [1:0]        psc_i,
  input  logic              clr_i,
  output logic              ti_o,
  output logic              ic_evt_o,
  output logic              ccif_o,
  output logic              ccof_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sy;
  logic [2:0]             div_q;
  logic                   stb;
  logic [FILT_W-1:0]      fc_q;
  logic [FILT_W-1:0]      filt_n_eff;
  logic [FILT_W:0]        fc_inc;
  logic                   reach;
  logic [FILT_W-1:0]      fc_sat;
  logic                   upd;
  logic                   qe;
  logic [1:0]             psc_q;
  logic [2:0]             ec_q;
  logic [2:0]             ec_base;
  logic [2:0]             psc_max;

  assign sy = sync_q[SYNC_STAGES-1];

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ch_i};
    end
  end

  // Free-running divider that sets the filter sampling rate.
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      div_q <= 3'd0;
    end else begin
      div_q <= div_q + 3'd1;
    end
  end

  // Strobe when the low fdiv_i bits of the divider are all zero.
  always_comb begin
    stb = 1'b1;
    case (fdiv_i)
      2'd0:    stb = 1'b1;
      2'd1:    stb = (div_q[0] == 1'b0);
      2'd2:    stb = (div_q[1:0] == 2'd0);
      default: stb = (div_q == 3'd0);
    endcase
  end

  // A zero length code behaves as a single-sample filter.
  assign filt_n_eff = (filt_n_i == '0) ? {{(FILT_W-1){1'b0}}, 1'b1} : filt_n_i;
  // One extra bit so the all-ones counter still compares correctly.
  assign fc_inc     = {1'b0, fc_q} + {{FILT_W{1'b0}}, 1'b1};
  assign reach      = (fc_inc >= {1'b0, filt_n_eff});
  assign fc_sat     = (&fc_q) ? fc_q : fc_inc[FILT_W-1:0];
  // The filtered level is about to flip on this edge.
  assign upd        = stb & (sy != ti_o) & reach;
  // Qualified edge: rising unless falling-only, falling when pol_i[0] is set.
  assign qe         = upd & ((sy & (pol_i != 2'b01)) | (~sy & pol_i[0]));

  // Filter: count consecutive differing strobes, flip the level at N.
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      ti_o <= 1'b0;
      fc_q <= '0;
    end else if (stb) begin
      if (sy == ti_o) begin
        fc_q <= '0;
      end else if (reach) begin
        ti_o <= sy;
        fc_q <= '0;
      end else begin
        fc_q <= fc_sat;
      end
    end
  end

  // Terminal edge count for the selected prescale ratio.
  always_comb begin
    psc_max = 3'd0;
    case (psc_i)
      2'd0:    psc_max = 3'd0;
      2'd1:    psc_max = 3'd1;
      2'd2:    psc_max = 3'd3;
      default: psc_max = 3'd7;
    endcase
  end

  // A prescaler change restarts the count in the same cycle.
  assign ec_base = (psc_i != psc_q) ? 3'd0 : ec_q;

  // Registered copy of the prescaler selection for change detection.
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      psc_q <= 2'd0;
    end else begin
      psc_q <= psc_i;
    end
  end

  // Prescaler: emit a one-cycle event every 2^psc_i qualified edges.
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      ec_q     <= 3'd0;
      ic_evt_o <= 1'b0;
    end else if (!en_i) begin
      ec_q     <= 3'd0;
      ic_evt_o <= 1'b0;
    end else begin
      ic_evt_o <= 1'b0;
      if (qe) begin
        if (ec_base == psc_max) begin
          ic_evt_o <= 1'b1;
          ec_q     <= 3'd0;
        end else begin
          ec_q <= ec_base + 3'd1;
        end
      end else begin
        ec_q <= ec_base;
      end
    end
  end

  // Sticky flags: an event beats a simultaneous clear for ccif_o.
  always_ff @(posedge aclk_i) begin
    if (areset_i) begin
      ccif_o <= 1'b0;
      ccof_o <= 1'b0;
    end else if (ic_evt_o) begin
      ccif_o <= 1'b1;
      if (clr_i) begin
        ccof_o <= 1'b0;
      end else if (ccif_o) begin
        ccof_o <= 1'b1;
      end
    end else if (clr_i) begin
      ccif_o <= 1'b0;
      ccof_o <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gpt_ic_conditioner.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gpt_ic_conditioner
// Purpose  : Self-checking bench for gpt_ic_conditioner: table vectors,
//            directed corner sequences and randomized stimulus against a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpt_ic_conditioner;

  localparam int FILT_W = 4;
  localparam int SYNC   = 2;

  logic              aclk = 1'b0;
  logic              areset = 1'b0;
  logic              en = 1'b0;
  logic              ch = 1'b0;
  logic [FILT_W-1:0] filt_n = '0;
  logic [1:0]        fdiv = 2'd0;
  logic [1:0]        pol = 2'd0;
  logic [1:0]        psc = 2'd0;
  logic              clr = 1'b0;
  logic              ti, ic_evt, ccif, ccof;

  int  checks = 0;
  int  errors = 0;
  int  evt_total = 0;
  bit  started = 0;
  bit  done = 0;
  bit  rand_on = 0;
  bit  slow = 0;
  bit  prev_evt = 0;

  gpt_ic_conditioner #(.FILT_W(FILT_W), .SYNC_STAGES(SYNC)) dut (
    .aclk_i(aclk), .areset_i(areset), .en_i(en), .ch_i(ch),
    .filt_n_i(filt_n), .fdiv_i(fdiv), .pol_i(pol), .psc_i(psc), .clr_i(clr),
    .ti_o(ti), .ic_evt_o(ic_evt), .ccif_o(ccif), .ccof_o(ccof)
  );

  always #5 aclk = ~aclk;

  // Reference model: pin delay line, strobe by cycle count, run-length
  // filter, qualified-edge tally, and flag rules applied to the old event.
  bit m_hist[$] = '{1'b0, 1'b0};
  int m_cyc = 0;
  int m_run = 0;
  int m_edges = 0;
  bit m_ti = 0, m_evt = 0, m_ccif = 0, m_ccof = 0;
  int m_lastpsc = 0;

  always @(posedge aclk) begin
    bit sy, qe, nevt, nccif, nccof, stb_now;
    int n;
    if (areset) begin
      m_hist.delete();
      for (int i = 0; i < SYNC; i++) m_hist.push_back(1'b0);
      m_cyc = 0; m_run = 0; m_edges = 0;
      m_ti = 0; m_evt = 0; m_ccif = 0; m_ccof = 0; m_lastpsc = 0;
    end else begin
      sy = m_hist[0];
      m_hist.delete(0);
      m_hist.push_back(ch);
      stb_now = ((m_cyc % (1 << fdiv)) == 0);
      m_cyc = m_cyc + 1;
      qe = 0;
      if (stb_now) begin
        n = (filt_n == 0) ? 1 : int'(filt_n);
        if (sy == m_ti) m_run = 0;
        else if (m_run + 1 >= n) begin
          qe = sy ? (pol != 2'b01) : (pol == 2'b01 || pol == 2'b11);
          m_ti = sy;
          m_run = 0;
        end else m_run = (m_run < 15) ? m_run + 1 : 15;
      end
      nevt = 0;
      if (!en) m_edges = 0;
      else begin
        if (int'(psc) != m_lastpsc) m_edges = 0;
        if (qe) begin
          m_edges = m_edges + 1;
          if (m_edges == (1 << psc)) begin nevt = 1; m_edges = 0; end
        end
      end
      nccif = m_ccif; nccof = m_ccof;
      if (m_evt && m_ccif && !clr) nccof = 1;
      if (m_evt) nccif = 1;
      if (clr && !m_evt) begin nccif = 0; nccof = 0; end
      if (clr && m_evt) nccof = 0;
      m_evt = nevt; m_ccif = nccif; m_ccof = nccof;
      m_lastpsc = int'(psc);
    end
  end

  typedef struct {
    logic [1:0] pol;
    logic [1:0] psc;
    int         toggles;
    int         exp_evts;
    logic       exp_ti;
    logic       exp_ccif;
    logic       exp_ccof;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic apply_reset();
    areset = 1; ch = 0; clr = 0;
    tick(3);
    areset = 0;
    started = 1;
  endtask

  task automatic cfg(input int f, input int d, input int p, input int s, input bit e);
    filt_n = FILT_W'(f); fdiv = 2'(d); pol = 2'(p); psc = 2'(s); en = e;
  endtask

  initial begin
    int base, lat;
    bit seen_hi;
    vecs[0] = '{2'b00, 2'd0, 1,  1, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{2'b00, 2'd0, 2,  1, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{2'b01, 2'd0, 2,  1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{2'b01, 2'd0, 1,  0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{2'b11, 2'd2, 8,  2, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{2'b11, 2'd1, 5,  2, 1'b1, 1'b1, 1'b1};
    vecs[6] = '{2'b10, 2'd0, 4,  2, 1'b0, 1'b1, 1'b1};
    vecs[7] = '{2'b00, 2'd3, 16, 1, 1'b0, 1'b1, 1'b0};
    vecs[8] = '{2'b11, 2'd3, 7,  0, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{2'b00, 2'd1, 6,  1, 1'b0, 1'b1, 1'b0};

    fork
      begin : stim
        // Reset state
        apply_reset();
        check("reset_ti", ti, 0); check("reset_evt", ic_evt, 0);
        check("reset_ccif", ccif, 0); check("reset_ccof", ccof, 0);

        // Table vectors in bypass filter mode
        for (int v = 0; v < 10; v++) begin
          apply_reset();
          cfg(0, 0, vecs[v].pol, vecs[v].psc, 1);
          tick(2);
          base = evt_total;
          for (int t = 0; t < vecs[v].toggles; t++) begin
            ch = ~ch;
            tick(5);
          end
          tick(4);
          check($sformatf("vec%0d_evts", v), evt_total - base, vecs[v].exp_evts);
          check($sformatf("vec%0d_ti", v), ti, vecs[v].exp_ti);
          check($sformatf("vec%0d_ccif", v), ccif, vecs[v].exp_ccif);
          check($sformatf("vec%0d_ccof", v), ccof, vecs[v].exp_ccof);
        end

        // Bypass latency: sampled at E0, ti and event at E2, flag at E3
        apply_reset();
        cfg(0, 0, 0, 0, 1);
        tick(3);
        ch = 1;
        @(posedge aclk);
        @(posedge aclk); #1;
        check("bypass_ti_e1", ti, 0);
        @(posedge aclk); #1;
        check("bypass_ti_e2", ti, 1);
        check("bypass_evt_e2", ic_evt, 1);
        @(posedge aclk); #1;
        check("bypass_evt_e3", ic_evt, 0);
        check("bypass_ccif_e3", ccif, 1);
        tick(1);
        base = evt_total;
        ch = 0;
        tick(6);
        check("bypass_fall_noevt", evt_total - base, 0);
        check("bypass_fall_ti", ti, 0);

        // Glitch rejection with N=4 sampled every 2 clocks
        apply_reset();
        cfg(4, 1, 0, 0, 1);
        tick(2);
        seen_hi = 0;
        ch = 1;
        for (int i = 0; i < 5; i++) begin tick(1); if (ti) seen_hi = 1; end
        ch = 0;
        for (int i = 0; i < 8; i++) begin tick(1); if (ti) seen_hi = 1; end
        check("glitch_5clk", seen_hi, 0);
        seen_hi = 0;
        ch = 1;
        for (int i = 0; i < 6; i++) begin tick(1); if (ti) seen_hi = 1; end
        ch = 0;
        for (int i = 0; i < 2; i++) begin tick(1); if (ti) seen_hi = 1; end
        ch = 1;
        for (int i = 0; i < 6; i++) begin tick(1); if (ti) seen_hi = 1; end
        ch = 0;
        for (int i = 0; i < 8; i++) begin tick(1); if (ti) seen_hi = 1; end
        check("glitch_restart", seen_hi, 0);
        ch = 1;
        lat = 0;
        while (!ti && lat < 20) begin tick(1); lat++; end
        check("glitch_hold_ti", ti, 1);
        check("glitch_hold_latency", int'(lat >= 9 && lat <= 10), 1);

        // Prescaler change after the 2nd edge restarts the count
        apply_reset();
        cfg(0, 0, 3, 2, 1);
        tick(2);
        base = evt_total;
        ch = 1; tick(5); ch = 0; tick(5);
        psc = 2'd1;
        tick(3);
        ch = 1; tick(5); ch = 0; tick(5);
        check("psc_change_evts", evt_total - base, 1);

        // Flags: overcapture, clear, clear concurrent with event
        apply_reset();
        cfg(0, 0, 0, 0, 1);
        tick(2);
        ch = 1; tick(5); ch = 0; tick(5);
        ch = 1; tick(5); ch = 0; tick(5);
        check("flag_ovr_ccif", ccif, 1);
        check("flag_ovr_ccof", ccof, 1);
        clr = 1; tick(1); clr = 0;
        check("flag_clr_ccif", ccif, 0);
        check("flag_clr_ccof", ccof, 0);
        ch = 1; tick(5); ch = 0; tick(5);
        ch = 1; tick(3);
        check("flag_evt_now", ic_evt, 1);
        clr = 1; tick(1); clr = 0;
        check("flag_clr_evt_ccif", ccif, 1);
        check("flag_clr_evt_ccof", ccof, 0);
        ch = 0; tick(5);

        // Enable gating: ti tracks, no events, count starts fresh
        apply_reset();
        cfg(0, 0, 0, 1, 0);
        tick(2);
        base = evt_total;
        for (int i = 0; i < 3; i++) begin
          ch = 1; tick(4);
          check($sformatf("en_off_ti%0d", i), ti, 1);
          ch = 0; tick(4);
        end
        check("en_off_evts", evt_total - base, 0);
        en = 1; tick(1);
        ch = 1; tick(5); ch = 0; tick(5);
        check("en_on_first_edge", evt_total - base, 0);
        ch = 1; tick(5); ch = 0; tick(5);
        check("en_on_second_edge", evt_total - base, 1);

        // Reset mid filter count and mid prescale
        apply_reset();
        cfg(0, 0, 0, 1, 1);
        tick(2);
        ch = 1; tick(5); ch = 0; tick(5);
        filt_n = 4'd4;
        ch = 1; tick(3);
        areset = 1; tick(1);
        check("midrst_ti", ti, 0); check("midrst_evt", ic_evt, 0);
        check("midrst_ccif", ccif, 0); check("midrst_ccof", ccof, 0);
        areset = 0;
        base = evt_total;
        tick(12);
        check("midrst_rise_ti", ti, 1);
        check("midrst_first_edge", evt_total - base, 0);
        ch = 0; tick(12); ch = 1; tick(12);
        check("midrst_second_edge", evt_total - base, 1);

        // Randomized sweep against the model
        rand_on = 1;
        for (int seg = 0; seg < 40; seg++) begin
          cfg($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), ($urandom_range(0, 4) != 0));
          slow = $urandom_range(0, 1);
          for (int c = 0; c < 150; c++) begin
            tick(1);
            clr = en && ($urandom_range(0, 15) == 0);
            areset = ($urandom_range(0, 399) == 0);
            if ($urandom_range(0, 99) == 0) psc = 2'($urandom_range(0, 3));
          end
        end
        clr = 0; areset = 0;
        rand_on = 0;
        tick(20);
        done = 1;
      end

      begin : pins
        while (!done) begin
          if (rand_on) begin
            #($urandom_range(3, 10) * (slow ? 6 : 1));
            if (($time % 10) == 5) #1;
            if (rand_on) ch = ~ch;
          end else begin
            @(negedge aclk);
          end
        end
      end

      begin : mon
        while (!done) begin
          @(negedge aclk);
          if (started) begin
            if (ic_evt) evt_total++;
            check("model_ti", ti, m_ti);
            check("model_evt", ic_evt, m_evt);
            check("model_ccif", ccif, m_ccif);
            check("model_ccof", ccof, m_ccof);
            check("evt_back_to_back", int'(ic_evt && prev_evt), 0);
            prev_evt = ic_evt;
          end
        end
      end
    join

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpt_ic_conditioner.md
Name: gpt_ic_conditioner

Overview:
Input-conditioning stage for one timer capture channel; one instance per `ch_i` bit sits directly upstream of the channel capture logic in `gpt_top`.
- Synchronises the asynchronous pin.
- Applies a digital noise filter with a programmable sampling rate.
- Detects edges of the selected polarity and divides them by a capture prescaler.
- Produces a filtered level, a one-cycle capture event, and sticky capture/overcapture flags.

Parameters:
- FILT_W, 4, width of the filter length code and of the filter counter.
- SYNC_STAGES, 2, number of synchroniser flops on `ch_i` (minimum 2).

Ports:
- aclk_i  in  1  clock.
- areset_i  in  1  reset; synchronous and active-high.
- en_i  in  1  channel capture enable.
- ch_i  in  1  raw asynchronous channel pin.
- filt_n_i  in  FILT_W  required count of consecutive equal samples; 0 is treated as 1.
- fdiv_i  in  2  filter sampling divider: strobe every 1, 2, 4 or 8 clocks.
- pol_i  in  2  edge select: 00 rising, 01 falling, 11 both, 10 reserved (acts as rising).
- psc_i  in  2  capture prescaler: event every 1, 2, 4 or 8 qualified edges.
- clr_i  in  1  clears `ccif_o` and `ccof_o`.
- ti_o  out  1  filtered, synchronised channel level.
- ic_evt_o  out  1  one-cycle capture event to the capture register.
- ccif_o  out  1  sticky capture flag.
- ccof_o  out  1  sticky overcapture flag.

Behaviour:
Reset (`areset_i` = 1 at a clock edge):
- Synchroniser flops, `ti_o`, `ic_evt_o`, `ccif_o`, `ccof_o`, the strobe divider, the filter counter and the edge counter all go to 0.
- Reset mid-operation discards any partial filter or prescaler count.
- A pin held high through reset produces one rising edge once it propagates after reset.

Synchroniser:
- `s[0]` <= `ch_i`; `s[k]` <= `s[k-1]`. `sy` = `s[SYNC_STAGES-1]`.

Strobe:
- A free-running 3-bit divider counts every clock.
- `stb` = 1 when the low `fdiv_i` bits of the divider are all 0. With `fdiv_i` = 0, every clock is a strobe.

Filter (`N` = max(`filt_n_i`, 1); counter `fc` is FILT_W bits):
- On `stb` with `sy` == `ti_o`: `fc` <= 0.
- On `stb` with `sy` != `ti_o`:
  - If `fc`+1 >= `N`: `ti_o` <= `sy` and `fc` <= 0.
  - Otherwise: `fc` <= `fc`+1, saturating at the all-ones value.
- No change to `ti_o` or `fc` on cycles without `stb`.
- Using >= means lowering `filt_n_i` mid-count takes effect on the next strobe without a stall.

Bypass latency (`N` = 1, `fdiv_i` = 0, SYNC_STAGES = 2):
- `ch_i` is first sampled high at edge E0; `ti_o` rises at E2.

Edge qualification (registered, same edge that updates `ti_o`):
- `rise` = `ti_o` updates 0->1; `fall` = `ti_o` updates 1->0.
- `qe` = (`rise` & `pol_i` != 01) | (`fall` & `pol_i` in {01, 11}).

Prescaler (edge counter `ec`, 3 bits):
- If `en_i` = 0: `ec` <= 0 and `ic_evt_o` <= 0.
- Else, on `qe`:
  - If `ec` == 2^`psc_i` - 1: `ic_evt_o` <= 1 and `ec` <= 0.
  - Otherwise: `ec` <= `ec`+1.
- `ic_evt_o` is 0 on all other cycles, so it is never high for two consecutive cycles.
- In bypass, `ic_evt_o` asserts in the same cycle `ti_o` changes.
- Any change of `psc_i` (compared with its registered copy) clears `ec` that cycle; a `qe` in that same cycle counts as the first edge (`ec` <= 1 or event if `psc_i` = 0).

Flags (evaluated in this order):
- `ic_evt_o` = 1 while `ccif_o` = 1 and `clr_i` = 0: `ccof_o` <= 1.
- `ic_evt_o` = 1: `ccif_o` <= 1 (event beats a simultaneous clear).
- `clr_i` = 1 and `ic_evt_o` = 0: `ccif_o` <= 0 and `ccof_o` <= 0.
- `clr_i` = 1 and `ic_evt_o` = 1: `ccif_o` = 1 and `ccof_o` <= 0.

Enable:
- `en_i` = 0 does not stop the synchroniser, filter or `ti_o`; it only gates events.
- Flags hold their values while `en_i` = 0.

Test Plan:
- Bypass (`filt_n_i`=0, `fdiv_i`=0, `pol_i`=00, `psc_i`=0, `en_i`=1): `ch_i` 0->1 sampled at E0 -> `ti_o`=1 and a single `ic_evt_o` pulse at E2; `ccif_o`=1 at E3. Falling `ch_i` -> no event.
- Glitch rejection (`filt_n_i`=4, `fdiv_i`=1): a 5-clock high pulse -> `ti_o` stays 0. A pulse held 8+ clocks -> `ti_o` rises on the 4th differing strobe; the count restarts if `ch_i` returns low between strobes.
- Both edges with divide-by-4 (`pol_i`=11, `psc_i`=2): 8 toggles of `ch_i` -> exactly 2 `ic_evt_o` pulses, on the 4th and 8th qualified edges. Changing `psc_i` after the 2nd edge restarts the count.
- Flags:
  - Two events with no `clr_i` -> `ccof_o`=1.
  - `clr_i` alone -> `ccif_o`=0 and `ccof_o`=0.
  - `clr_i` in the same cycle as an event -> `ccif_o`=1, `ccof_o`=0.
- Enable and reset:
  - `en_i`=0 during 3 rising edges -> `ti_o` tracks the pin, no events, `ec`=0.
  - `areset_i` pulsed mid filter count and mid prescale -> all outputs 0 the next cycle; the first event needs a full `N` samples and 2^`psc_i` edges.
- Random stimulus (`ch_i` toggling every 3-10 ns against a 10 ns clock, all configurations swept) -> scoreboard model matches `ti_o`, `ic_evt_o`, `ccif_o` and `ccof_o` cycle-exactly; `ic_evt_o` is never high two cycles in a row.
